// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller.
//   state_t    : controller FSM states (IDLE, CONV, DONE)
//   SEG_BLANK  : active-low pattern with every segment off
//   SEG_DASH   : active-low pattern showing only segment g (a dash)
//   hex_to_seg : nibble -> active-low gfedcba glyph
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Bit order is gfedcba, a segment is lit when its bit is 0.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value-input channel of the display controller.
//   in_valid : producer offers a value
//   in_ready : controller can take a value
//   in_data  : binary value
//   mode_dec : 0 = show as hex, 1 = show as decimal
//   blank_lz : blank leading zeros
// Handshake: a transfer happens on every rising clock edge where in_valid and
// in_ready are both 1; in_data, mode_dec and blank_lz are captured on that edge.
// While in_ready is 0 the offered value is ignored and nothing is captured; the
// producer may hold or change its offer freely, it is only taken once in_ready=1.
interface hex_display_ctrl_if #(
   parameter int DATA_W = 20
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              mode_dec;
   logic              blank_lz;

   modport master (
      output in_valid,
      output in_data,
      output mode_dec,
      output blank_lz,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  mode_dec,
      input  blank_lz,
      output in_ready
   );
endinterface

// File: rtl/hex_display_ctrl_bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
//   clk, resetn : clock, synchronous active-low reset
//   start       : load bin and begin a conversion (DATA_W shift cycles follow)
//   bin         : binary value, sampled when start=1
//   done        : high during the cycle in which the final shift is taken;
//                 bcd/ovf hold the finished result from the next cycle on
//   bcd         : NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
//   ovf         : a 1 was shifted out of the top digit (value >= 10**NUM_DIGITS)
module bin2bcd_seq #(
   parameter int DATA_W     = 20,
   parameter int NUM_DIGITS = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [DATA_W-1:0]       bin,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sh_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  adj;
   logic              ovf_q;
   logic              running_q;
   logic [CNT_W-1:0]  cnt_q;

   // Add-3 correction applied to the current digits before each shift.
   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sh_q      <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else if (start) begin
         sh_q      <= bin;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b1;
         cnt_q     <= '0;
      end else if (running_q) begin
         bcd_q <= {adj[BCD_W-2:0], sh_q[DATA_W-1]};
         sh_q  <= sh_q << 1;
         // The bit leaving the top digit is a carry into a digit we do not have.
         ovf_q <= ovf_q | adj[BCD_W-1];
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_W'(DATA_W - 1)) begin
            running_q <= 1'b0;
         end
      end
   end

   assign done = running_q && (cnt_q == CNT_W'(DATA_W - 1));
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller for a bank of NUM_DIGITS digits.
// Values arrive over a valid/ready channel and are shown as hex (immediately)
// or decimal (after a DATA_W-cycle double-dabble), with optional leading-zero
// blanking, a dash pattern on decimal overflow and per-digit blinking.
//   CLOCK_50 : system clock
//   resetn   : synchronous active-low reset
//   bus      : value channel (slave side: in_valid/in_data/mode_dec/blank_lz in, in_ready out)
//   blink_en : per-digit blink enable, used live
//   seg_n    : active-low gfedcba, seg_n[7*i+:7] is digit i (i=0 least significant)
//   busy     : decimal conversion in progress
//   overflow : last decimal value did not fit in NUM_DIGITS digits
//   state    : current FSM state (observation port)
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20,
   parameter int CLK_HZ     = 50_000_000,
   parameter int BLINK_HZ   = 2
) (
   input  logic                    CLOCK_50,
   input  logic                    resetn,
   hex_display_ctrl_if.slave       bus,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   output logic [7*NUM_DIGITS-1:0] seg_n,
   output logic                    busy,
   output logic                    overflow,
   output state_t                  state
);

   localparam int BCD_W    = 4 * NUM_DIGITS;
   localparam int CP_W     = (DATA_W < BCD_W) ? DATA_W : BCD_W;
   localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int BC_W     = (HALF > 1) ? $clog2(HALF) : 1;

   state_t                       state_q, state_d;
   logic                         accept;
   logic                         start_dec;
   logic                         load_hex;
   logic                         load_dec;
   logic                         conv_done;
   logic [BCD_W-1:0]             conv_bcd;
   logic                         conv_ovf;
   logic                         blank_q;
   logic [BCD_W-1:0]             nib;
   logic                         lz_en;
   logic                         dash;
   logic                         higher_nz;
   logic [NUM_DIGITS-1:0][6:0]   glyph_d;
   logic [NUM_DIGITS-1:0][6:0]   digit_q;
   logic                         overflow_q;
   logic [BC_W-1:0]              blink_cnt_q;
   logic                         phase_q;

   assign bus.in_ready = (state_q == IDLE);
   assign accept       = bus.in_valid && bus.in_ready;
   assign start_dec    = accept && bus.mode_dec;
   assign load_hex     = accept && !bus.mode_dec;
   assign load_dec     = (state_q == DONE);

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .start  (start_dec),
      .bin    (bus.in_data),
      .done   (conv_done),
      .bcd    (conv_bcd),
      .ovf    (conv_ovf)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_dec) state_d = CONV;
         CONV:    if (conv_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // blank_lz must survive the whole conversion for a decimal value.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         blank_q <= 1'b0;
      end else if (start_dec) begin
         blank_q <= bus.blank_lz;
      end
   end

   // ---------------- Glyph rendering ----------------
   // Source nibbles: the BCD result when finishing a conversion, otherwise the
   // incoming word (hex), with nibbles beyond DATA_W reading as zero.
   always_comb begin
      nib = '0;
      if (load_dec) begin
         nib = conv_bcd;
      end else begin
         nib[CP_W-1:0] = bus.in_data[CP_W-1:0];
      end
   end

   assign lz_en = load_dec ? blank_q : bus.blank_lz;
   assign dash  = load_dec && conv_ovf;

   // Walk from the top digit down; a digit is a leading zero while it and
   // every digit above it are zero. Digit 0 is always drawn.
   always_comb begin
      higher_nz = 1'b0;
      glyph_d   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         higher_nz = higher_nz | (nib[4*i +: 4] != 4'd0);
         if (dash) begin
            glyph_d[i] = SEG_DASH;
         end else if (lz_en && !higher_nz && (i != 0)) begin
            glyph_d[i] = SEG_BLANK;
         end else begin
            glyph_d[i] = hex_to_seg(nib[4*i +: 4]);
         end
      end
   end

   // ---------------- Digit registers / overflow ----------------
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= SEG_BLANK;
         end
         overflow_q <= 1'b0;
      end else if (load_hex) begin
         digit_q    <= glyph_d;
         overflow_q <= 1'b0;
      end else if (load_dec) begin
         digit_q    <= glyph_d;
         overflow_q <= conv_ovf;
      end
   end

   // ---------------- Blink prescaler ----------------
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BC_W'(HALF - 1)) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   // ---------------- Output register ----------------
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         seg_n <= '1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_n[7*i +: 7] <= (phase_q && blink_en[i]) ? SEG_BLANK : digit_q[i];
         end
      end
   end

   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;
   assign state    = state_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
   import hex_display_pkg::*;

   localparam int ND       = 6;
   localparam int DW       = 20;
   localparam int CLK_HZ   = 100;
   localparam int BLINK_HZ = 5;
   localparam int HALF     = 10;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [ND-1:0] blink_en = '0;
   logic [7*ND-1:0] seg_n;
   logic          busy;
   logic          overflow;
   state_t        state;

   hex_display_ctrl_if #(.DATA_W(DW)) bus ();

   hex_display_ctrl #(
      .NUM_DIGITS (ND),
      .DATA_W     (DW),
      .CLK_HZ     (CLK_HZ),
      .BLINK_HZ   (BLINK_HZ)
   ) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus),
      .blink_en (blink_en),
      .seg_n    (seg_n),
      .busy     (busy),
      .overflow (overflow),
      .state    (state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // What the six digits must show for value v, from plain arithmetic.
   function automatic logic [7*ND-1:0] render(input int unsigned v, input bit dec, input bit blz);
      logic [7*ND-1:0] r;
      int unsigned     base;
      int unsigned     pw;
      logic [3:0]      d;
      r    = '1;
      base = dec ? 10 : 16;
      pw   = 1;
      for (int i = 0; i < ND; i++) begin
         d = 4'((v / pw) % base);
         if (dec && v >= 1000000) r[7*i +: 7] = 7'h3F;
         else if (blz && i > 0 && v < pw) r[7*i +: 7] = 7'h7F;
         else r[7*i +: 7] = seg_tab[d];
         pw = pw * base;
      end
      return r;
   endfunction

   bit              model_on = 1'b0;
   logic [7*ND-1:0] m_disp;
   logic [7*ND-1:0] m_seg;
   bit              m_ready;
   bit              m_ovf;
   int              m_left;       // busy cycles still to come for a decimal value
   int unsigned     m_ticks;      // clock edges since reset
   int unsigned     p_val;
   bit              p_blz;

   always @(posedge clk) begin
      if (!resetn) begin
         model_on = 1'b1;
         m_disp   = '1;
         m_seg    = '1;
         m_ready  = 1'b1;
         m_ovf    = 1'b0;
         m_left   = 0;
         m_ticks  = 0;
      end else if (model_on) begin
         for (int i = 0; i < ND; i++) begin
            m_seg[7*i +: 7] = ((((m_ticks / HALF) % 2) == 1) && blink_en[i]) ? 7'h7F : m_disp[7*i +: 7];
         end
         m_ticks++;
         if (bus.in_valid && m_ready) begin
            if (!bus.mode_dec) begin
               m_disp = render(bus.in_data, 1'b0, bus.blank_lz);
               m_ovf  = 1'b0;
            end else begin
               m_ready = 1'b0;
               m_left  = DW + 1;
               p_val   = bus.in_data;
               p_blz   = bus.blank_lz;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_disp  = render(p_val, 1'b1, p_blz);
               m_ovf   = (p_val >= 1000000);
               m_ready = 1'b1;
            end
         end
      end
   end

   // One compare process, every cycle once the model is running.
   always @(negedge clk) begin
      if (model_on) begin
         check("seg_n",    64'(seg_n),         64'(m_seg));
         check("in_ready", 64'(bus.in_ready),  64'(m_ready));
         check("busy",     64'(busy),          64'(m_left > 0));
         check("overflow", 64'(overflow),      64'(m_ovf));
         check("state",    64'(state),
               64'((m_left == 0) ? IDLE : ((m_left == 1) ? DONE : CONV)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a value and return one step after the edge that took it (cycle T+1).
   task automatic send(input int unsigned v, input bit dec, input bit blz);
      bit acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(v);
      bus.mode_dec = dec;
      bus.blank_lz = blz;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) check("send_timeout", 64'(acc), 64'(1));
   endtask

   function automatic logic [7*ND-1:0] glyphs(input logic [6:0] g5, input logic [6:0] g4,
                                              input logic [6:0] g3, input logic [6:0] g2,
                                              input logic [6:0] g1, input logic [6:0] g0);
      return {g5, g4, g3, g2, g1, g0};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int unsigned blanks;
      int unsigned r;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.mode_dec = 1'b0;
      bus.blank_lz = 1'b0;

      // Reset values
      #1;
      tick(2);
      check("rst_seg",      64'(seg_n),        64'(42'h3FF_FFFF_FFFF));
      check("rst_ready",    64'(bus.in_ready), 64'(1));
      check("rst_busy",     64'(busy),         64'(0));
      check("rst_overflow", 64'(overflow),     64'(0));
      resetn = 1'b1;
      tick(1);

      // Hex: digits update at T+1, seg_n at T+2
      send(32'hABCDE, 1'b0, 1'b0);
      check("hex_ready_t1", 64'(bus.in_ready), 64'(1));
      check("hex_seg_t1",   64'(seg_n),        64'(42'h3FF_FFFF_FFFF));
      tick(1);
      check("hex_seg_t2", 64'(seg_n),
            64'(glyphs(7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06)));
      check("hex_hex5", 64'(seg_n[41:35]), 64'(7'h40));
      check("hex_hex0", 64'(seg_n[6:0]),   64'(7'h06));

      // Decimal 123456
      send(123456, 1'b1, 1'b0);
      check("dec_ready_t1", 64'(bus.in_ready), 64'(0));
      check("dec_busy_t1",  64'(busy),         64'(1));
      tick(20);
      check("dec_ready_t21", 64'(bus.in_ready), 64'(0));
      tick(1);
      check("dec_ready_t22", 64'(bus.in_ready), 64'(1));
      check("dec_seg_t22", 64'(seg_n),
            64'(glyphs(7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06)));
      tick(1);
      check("dec_seg_t23", 64'(seg_n),
            64'(glyphs(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));
      check("dec_overflow", 64'(overflow), 64'(0));

      // Overflow, then blanking of 42
      send(1000000, 1'b1, 1'b0);
      tick(22);
      check("ovf_seg",  64'(seg_n),    64'({6{7'h3F}}));
      check("ovf_flag", 64'(overflow), 64'(1));
      send(42, 1'b1, 1'b1);
      tick(22);
      check("lz42_seg", 64'(seg_n),
            64'(glyphs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24)));
      check("lz42_overflow", 64'(overflow), 64'(0));

      // Blink HEX0 only: over 40 cycles exactly half are blank
      blink_en = 6'b000001;
      tick(2);
      blanks = 0;
      for (int k = 0; k < 40; k++) begin
         if (seg_n[6:0] == 7'h7F) blanks++;
         else check("blink_on_glyph", 64'(seg_n[6:0]), 64'(7'h24));
         check("blink_upper", 64'(seg_n[41:7]),
               64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19}));
         tick(1);
      end
      check("blink_blank_cycles", 64'(blanks), 64'(20));
      blink_en = '0;
      tick(2);

      // Hex zero with blanking renders a single "0"
      send(0, 1'b0, 1'b1);
      tick(1);
      check("zero_seg", 64'(seg_n),
            64'(glyphs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));

      // Offers during a conversion are ignored
      send(654321, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(111111);
      bus.mode_dec = 1'b0;
      tick(15);
      bus.in_valid = 1'b0;
      tick(7);
      check("ignore_seg", 64'(seg_n),
            64'(glyphs(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79)));

      // Reset in the middle of a conversion
      send(999, 1'b1, 1'b0);
      tick(4);
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(1);
      check("abort_ready", 64'(bus.in_ready), 64'(1));
      check("abort_seg",   64'(seg_n),        64'(42'h3FF_FFFF_FFFF));
      tick(30);
      check("abort_no_late_seg", 64'(seg_n),    64'(42'h3FF_FFFF_FFFF));
      check("abort_overflow",    64'(overflow), 64'(0));

      // Randomised traffic, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       bus.in_data = DW'($urandom_range(0, 99));
            1:       bus.in_data = DW'($urandom_range(999_990, 1_000_010));
            default: bus.in_data = DW'($urandom);
         endcase
         bus.in_valid = ($urandom_range(0, 3) == 0);
         bus.mode_dec = $urandom_range(0, 1) == 1;
         bus.blank_lz = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 63) == 0) blink_en = ND'($urandom);
         resetn = ($urandom_range(0, 999) != 0);
         tick(1);
      end
      resetn       = 1'b1;
      bus.in_valid = 1'b0;
      tick(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
